// File: rtl/astar_result_streamer.sv
// astar_result_streamer: snapshots the astar_top results on each rising edge of
// done and streams them as one framed byte sequence over a valid/ready port.
// Frame: sync, tag, flags, start, goal, path_length, cycles, nodes, cost,
// obstacle map bytes, path map bytes.
// Optional feature macro RESULT_CHECKSUM_EN appends an 8-bit sum of bytes 1..last.
module astar_result_streamer #(
    parameter int unsigned GRID_SIZE  = 16,
    parameter int unsigned COORD_BITS = 4,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            done,
    input  logic [7:0]                      test_tag,
    input  logic                            path_found,
    input  logic                            timeout_error,
    input  logic [COORD_BITS-1:0]           start_x,
    input  logic [COORD_BITS-1:0]           start_y,
    input  logic [COORD_BITS-1:0]           goal_x,
    input  logic [COORD_BITS-1:0]           goal_y,
    input  logic [7:0]                      path_length,
    input  logic [31:0]                     cycles_taken,
    input  logic [15:0]                     nodes_expanded,
    input  logic [15:0]                     path_cost,
    input  logic [GRID_SIZE*GRID_SIZE-1:0]  obstacle_map,
    input  logic [GRID_SIZE*GRID_SIZE-1:0]  path_map,
    output logic [7:0]                      tx_data,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            overrun
);

    localparam int unsigned MAP_BITS  = GRID_SIZE * GRID_SIZE;
    localparam int unsigned MAP_BYTES = MAP_BITS / 8;
    localparam int unsigned HDR_BYTES = 14;
    localparam int unsigned CNT_W     = 8;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(HDR_BYTES + 2 * MAP_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        CKSUM = 2'd2,
        FIN   = 2'd3
    } state_e;

    typedef struct packed {
        logic [7:0]          tag;
        logic                timeout_error;
        logic                path_found;
        logic [3:0]          sx;
        logic [3:0]          sy;
        logic [3:0]          gx;
        logic [3:0]          gy;
        logic [7:0]          plen;
        logic [31:0]         cycles;
        logic [15:0]         nodes;
        logic [15:0]         cost;
        logic [MAP_BITS-1:0] obs;
        logic [MAP_BITS-1:0] pmap;
    } snap_t;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               overrun_q, overrun_d;
    logic               done_q, done_d;
    snap_t              snap_q, snap_d;
`ifdef RESULT_CHECKSUM_EN
    logic [7:0]         cks_q, cks_d;
`endif

    logic               capture_c;
    logic               xfer_c;
    logic [CNT_W-1:0]   nxt_idx_c;
    int unsigned        nxt_off_c;
    logic [7:0]         byte_c;

    assign capture_c = done & ~done_q;
    assign xfer_c    = tx_valid_q & tx_ready;

    // Frame byte that follows the one currently presented, taken from the snapshot
    always_comb begin
        nxt_idx_c = cnt_q + CNT_W'(1);
        nxt_off_c = 32'(nxt_idx_c);
        byte_c    = 8'h00;
        case (nxt_idx_c)
            8'd1:  byte_c = snap_q.tag;
            8'd2:  byte_c = {6'b0, snap_q.timeout_error, snap_q.path_found};
            8'd3:  byte_c = {snap_q.sx, snap_q.sy};
            8'd4:  byte_c = {snap_q.gx, snap_q.gy};
            8'd5:  byte_c = snap_q.plen;
            8'd6:  byte_c = snap_q.cycles[31:24];
            8'd7:  byte_c = snap_q.cycles[23:16];
            8'd8:  byte_c = snap_q.cycles[15:8];
            8'd9:  byte_c = snap_q.cycles[7:0];
            8'd10: byte_c = snap_q.nodes[15:8];
            8'd11: byte_c = snap_q.nodes[7:0];
            8'd12: byte_c = snap_q.cost[15:8];
            8'd13: byte_c = snap_q.cost[7:0];
            default: begin
                if (nxt_off_c >= HDR_BYTES && nxt_off_c < HDR_BYTES + MAP_BYTES) begin
                    byte_c = snap_q.obs[8 * (nxt_off_c - HDR_BYTES) +: 8];
                end else if (nxt_off_c >= HDR_BYTES + MAP_BYTES &&
                             nxt_off_c <  HDR_BYTES + 2 * MAP_BYTES) begin
                    byte_c = snap_q.pmap[8 * (nxt_off_c - HDR_BYTES - MAP_BYTES) +: 8];
                end
            end
        endcase
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q | (capture_c & busy_q);
        done_d       = done;
        snap_d       = snap_q;
`ifdef RESULT_CHECKSUM_EN
        cks_d        = cks_q;
`endif
        case (state_q)
            IDLE: begin
                if (capture_c) begin
                    snap_d.tag           = test_tag;
                    snap_d.timeout_error = timeout_error;
                    snap_d.path_found    = path_found;
                    snap_d.sx            = 4'(start_x);
                    snap_d.sy            = 4'(start_y);
                    snap_d.gx            = 4'(goal_x);
                    snap_d.gy            = 4'(goal_y);
                    snap_d.plen          = path_length;
                    snap_d.cycles        = cycles_taken;
                    snap_d.nodes         = nodes_expanded;
                    snap_d.cost          = path_cost;
                    snap_d.obs           = obstacle_map;
                    snap_d.pmap          = path_map;
                    state_d              = SEND;
                    cnt_d                = '0;
                    tx_data_d            = SYNC_BYTE;
                    tx_valid_d           = 1'b1;
                    busy_d               = 1'b1;
`ifdef RESULT_CHECKSUM_EN
                    cks_d                = 8'h00;
`endif
                end
            end
            SEND: begin
                if (xfer_c) begin
`ifdef RESULT_CHECKSUM_EN
                    if (cnt_q != '0) begin
                        cks_d = cks_q + tx_data_q;
                    end
`endif
                    if (cnt_q == LAST_IDX) begin
`ifdef RESULT_CHECKSUM_EN
                        state_d   = CKSUM;
                        cnt_d     = nxt_idx_c;
                        tx_data_d = cks_q + tx_data_q;
`else
                        state_d      = FIN;
                        tx_data_d    = 8'h00;
                        tx_valid_d   = 1'b0;
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
`endif
                    end else begin
                        cnt_d     = nxt_idx_c;
                        tx_data_d = byte_c;
                    end
                end
            end
`ifdef RESULT_CHECKSUM_EN
            CKSUM: begin
                if (xfer_c) begin
                    state_d      = FIN;
                    tx_data_d    = 8'h00;
                    tx_valid_d   = 1'b0;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                end
            end
`endif
            FIN: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            done_q       <= 1'b0;
            snap_q       <= '0;
`ifdef RESULT_CHECKSUM_EN
            cks_q        <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            done_q       <= done_d;
            snap_q       <= snap_d;
`ifdef RESULT_CHECKSUM_EN
            cks_q        <= cks_d;
`endif
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: doc/astar_result_streamer.md
Name: astar_result_streamer

Overview:
- Byte-serial reader for the astar_top result interface.
- On each search completion it snapshots every result output plus the obstacle map and streams them as one framed byte sequence over a valid/ready interface, for a UART/USB bridge or capture FIFO.
- Hardware counterpart of the bench's result export: same fields, fixed binary frame order.

Parameters:
GRID_SIZE, 16, grid edge length; GRID_SIZE*GRID_SIZE must be a multiple of 8
COORD_BITS, 4, coordinate width; must be <=4, zero-extended into a nibble
SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-low reset
done  in  1  astar_top completion, level; rising edge triggers capture
test_tag  in  8  frame identifier, captured with results
path_found  in  1  result flag
timeout_error  in  1  result flag
start_x, start_y, goal_x, goal_y  in  COORD_BITS each  search endpoints
path_length  in  8  result
cycles_taken  in  32  result
nodes_expanded  in  16  result
path_cost  in  16  result
obstacle_map  in  GRID_SIZE*GRID_SIZE  bit r*GRID_SIZE+c = cell (c,r)
path_map  in  GRID_SIZE*GRID_SIZE  same indexing
tx_data  out  8  stream byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  sink accepts
busy  out  1  frame capture/transmit in progress
frame_done  out  1  one-cycle pulse after the last byte is accepted
overrun  out  1  sticky: done rose while busy

Behaviour:
- Reset (rst=0 at a clock edge): tx_valid=0, tx_data=0, busy=0, frame_done=0, overrun=0; state IDLE; byte counter 0; checksum 0; done-edge register 0. Reset mid-frame aborts the frame; nothing resumes after release.
- Edge detect: done_q registers done. A capture event is done & ~done_q.
- IDLE: on a capture event, latch all inputs into snapshot registers, go to SEND, set busy. tx_valid=1 with byte 0 on the following cycle (1-cycle latency).
- Capture event while busy: ignored, snapshot unchanged, overrun set (cleared only by reset).
- Handshake: a transfer occurs when tx_valid & tx_ready. While tx_valid=1 & tx_ready=0, tx_data is held stable. tx_valid never drops mid-frame. After each transfer the next byte is presented on the following cycle; back-to-back transfers run at 1 byte/cycle.
- Frame order:
  - 0: SYNC_BYTE
  - 1: test_tag
  - 2: {6'b0, timeout_error, path_found}
  - 3: {start_x, start_y}, x in [7:4]
  - 4: {goal_x, goal_y}
  - 5: path_length
  - 6-9: cycles_taken, MSB first
  - 10-11: nodes_expanded, MSB first
  - 12-13: path_cost, MSB first
  - next MB=GRID_SIZE*GRID_SIZE/8 bytes: obstacle_map, byte k = bits [8k+7:8k]
  - next MB bytes: path_map, same packing
- Default frame: 14+32+32 = 78 bytes. Byte counter is 8 bits wide and never wraps within a frame.
- States: IDLE -> SEND -> (CKSUM if enabled) -> FIN -> IDLE.
  - FIN asserts frame_done for 1 cycle, clears busy and drops tx_valid. A new capture is accepted in the IDLE cycle after FIN.
- A done level held high across frames does not retrigger; it must fall and rise again.
- Snapshot isolation: input changes after capture do not affect the frame in flight.

Optional Feature:
- Macro RESULT_CHECKSUM_EN.
  - Defined: state CKSUM appends one byte after the path map. The byte is the 8-bit sum mod 256 of frame bytes 1 through last map byte (sync excluded). Frame is 79 bytes. The checksum accumulator updates on each accepted byte.
  - Undefined: no accumulator, no CKSUM state; SEND goes directly to FIN after the last map byte. Frame is 78 bytes.

Test Plan:
- Reset values: hold rst=0 for 5 cycles with done=1 -> all outputs 0; after release with done still 1 and done_q from reset = 0 -> a capture occurs, first byte 0xA5 one cycle later.
- Row-7 wall frame: tag=7, path_found=0, start (0,0), goal (15,15), cycles=0x123, nodes=0x80, cost=0, obstacle row 7 full, path_map=0, tx_ready=1. Required response:
  - 79 consecutive valid cycles.
  - Bytes 1-13 = 07 00 00 FF 00 00 00 01 23 00 80 00 00.
  - Bytes 28,29 = FF FF; all other map bytes 00.
  - Checksum = 0xA8.
  - frame_done pulses the cycle after byte 78.
- Backpressure: tx_ready=0 for 10 cycles while byte 5 is presented -> tx_data holds path_length, no byte skipped or duplicated, total accepted count unchanged.
- Overrun: pulse done again at byte 20 with different inputs -> overrun=1, frame contents still match the first snapshot, no second frame.
- Reset mid-frame: rst=0 at byte 40 -> next cycle tx_valid=0, busy=0. A later done edge yields a complete frame starting with 0xA5.
- Macro off: repeat the row-7 case -> exactly 78 bytes, frame_done after the last path_map byte.
